// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and default sizes for the packet-buffer port arbiter
package ram_arb_pkg;

  localparam int AW_DEF        = 14;
  localparam int DW_DEF        = 16;
  localparam int BEW_DEF       = 2;
  localparam int MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arb_rd_tag.sv
// rtl/ram_arb_rd_tag.sv - two-stage read tag pipeline steering rvalid to the issuing requester
// Stage 1 lines up with the registered RAM beat, stage 2 with the RAM's registered output.
module ram_arb_rd_tag (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_valid,
  input  logic rd_id,
  output logic m0_rvalid,
  output logic m1_rvalid
);

  logic s1_valid_q, s1_valid_d;
  logic s1_id_q, s1_id_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_id_q, s2_id_d;

  always_comb begin
    s1_valid_d = rd_valid;
    s1_id_d    = rd_id;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign m0_rvalid = s2_valid_q & ~s2_id_q;
  assign m1_rvalid = s2_valid_q & s2_id_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin burst-locking arbiter sharing one packet-buffer RAM port
// m0 is the Ethernet RX writer, m1 the PCIe host side; RAM-side signals are registered.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int BEW       = BEW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           m0_req,
  input  logic           m0_wr,
  input  logic [BEW-1:0] m0_be,
  input  logic [AW-1:0]  m0_addr,
  input  logic [DW-1:0]  m0_wdata,
  output logic           m0_gnt,
  output logic           m0_rvalid,
  output logic [DW-1:0]  m0_rdata,
  input  logic           m1_req,
  input  logic           m1_wr,
  input  logic [BEW-1:0] m1_be,
  input  logic [AW-1:0]  m1_addr,
  input  logic [DW-1:0]  m1_wdata,
  output logic           m1_gnt,
  output logic           m1_rvalid,
  output logic [DW-1:0]  m1_rdata,
  output logic           ram_en,
  output logic           ram_wr,
  output logic [BEW-1:0] ram_be,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_din,
  input  logic [DW-1:0]  ram_q
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap;

  logic           ram_en_q, ram_en_d;
  logic           ram_wr_q, ram_wr_d;
  logic [BEW-1:0] ram_be_q, ram_be_d;
  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic [DW-1:0]  ram_din_q, ram_din_d;
  logic           acc, sel, sel_wr, rd_valid;

  // The burst cap only bites when the other side is waiting; a lone owner streams freely.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    cap     = (cnt_q == CW'(MAX_BURST));

    case (state_q)
      ST_OWN0: begin
        m0_gnt = m0_req & ~(cap & m1_req);
        m1_gnt = m1_req & ~m0_gnt;
      end
      ST_OWN1: begin
        m1_gnt = m1_req & ~(cap & m0_req);
        m0_gnt = m0_req & ~m1_gnt;
      end
      default: begin
        m0_gnt = m0_req & (~m1_req | last_q);
        m1_gnt = m1_req & ~m0_gnt;
      end
    endcase

    if (m0_gnt) begin
      state_d = ST_OWN0;
      last_d  = 1'b0;
      cnt_d   = (state_q == ST_OWN0) ? (cap ? cnt_q : cnt_q + CW'(1)) : CW'(1);
    end else if (m1_gnt) begin
      state_d = ST_OWN1;
      last_d  = 1'b1;
      cnt_d   = (state_q == ST_OWN1) ? (cap ? cnt_q : cnt_q + CW'(1)) : CW'(1);
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    acc        = m0_gnt | m1_gnt;
    sel        = m1_gnt;
    sel_wr     = sel ? m1_wr : m0_wr;
    ram_en_d   = acc;
    ram_wr_d   = acc & sel_wr;
    ram_be_d   = ram_wr_d ? (sel ? m1_be : m0_be) : '0;
    ram_addr_d = acc ? (sel ? m1_addr : m0_addr) : ram_addr_q;
    ram_din_d  = acc ? (sel ? m1_wdata : m0_wdata) : ram_din_q;
    rd_valid   = acc & ~sel_wr;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_be_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ram_en_q   <= ram_en_d;
      ram_wr_q   <= ram_wr_d;
      ram_be_q   <= ram_be_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  ram_arb_rd_tag u_rd_tag (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .rd_valid  (rd_valid),
    .rd_id     (sel),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid)
  );

  assign ram_en   = ram_en_q;
  assign ram_wr   = ram_wr_q;
  assign ram_be   = ram_be_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign m0_rdata = ram_q;
  assign m1_rdata = ram_q;

endmodule
